// File: rtl/cve2_mem_responder.sv
// cve2_mem_responder: req/gnt/rvalid memory slave over a byte-enabled word RAM; optional integrity via CVE2_MEM_RESP_INTG_EN.
// Latency: grant once req_i has been held GntDelay cycles; response RespLatency cycles after the accepting edge.
// Backpressure: grant withheld while MaxOutstanding responses are in flight; responses themselves never stall.
module cve2_mem_responder #(
  parameter int unsigned Depth          = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(Depth);

  typedef struct packed {
    logic        vld;
    logic [31:0] rdata;
    logic [6:0]  intg;
    logic        err;
  } resp_t;

  logic [31:0]   mem [Depth];
  resp_t         pipe [RespLatency];
  resp_t         resp_new;
  logic [3:0]    stall_cnt;
  logic [3:0]    outstanding;
  logic          active;
  logic          accept;
  logic          in_range;
  logic          intg_bad;
  logic          wr_en;
  logic [31:0]   offset;
  logic [31:0]   rd_word;
  logic [AW-1:0] idx;
  logic          unused_addr;

  // Unsigned subtraction folds "below base" into "far above range", so one compare covers both.
  assign offset      = addr_i - BaseAddr;
  assign in_range    = {1'b0, offset} < (33'(Depth) << 2);
  assign idx         = offset[AW+1:2];
  assign unused_addr = ^offset[1:0];

  // active gates the grant so nothing is accepted while (or in the cycle) reset is released.
  assign gnt_o  = req_i & active & (stall_cnt >= 4'(GntDelay))
                        & (outstanding < 4'(MaxOutstanding));
  assign accept = req_i & gnt_o;

  assign rd_word = mem[idx];
  assign wr_en   = accept & we_i & in_range & ~intg_bad;

`ifdef CVE2_MEM_RESP_INTG_EN
  // Inverted SECDED(39,32) check bits; the inversion makes all-zero words carry non-zero check bits.
  function automatic logic [6:0] secded_inv_enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c ^ 7'h2A;
  endfunction

  assign intg_bad = we_i & (wdata_intg_i != secded_inv_enc(wdata_i));
`else
  logic unused_intg;
  assign unused_intg = ^wdata_intg_i;
  assign intg_bad    = 1'b0;
`endif

  // Build the response for this cycle's accept; idle stages carry all-zero entries.
  always_comb begin
    resp_new     = '0;
    resp_new.vld = accept;
    resp_new.err = accept & (~in_range | intg_bad);
    if (accept & ~we_i & in_range) begin
      resp_new.rdata = rd_word;
    end
`ifdef CVE2_MEM_RESP_INTG_EN
    if (accept) begin
      resp_new.intg = secded_inv_enc(resp_new.rdata);
    end
`endif
  end

  // RAM write with per-byte enables; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Response shift register; reset drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RespLatency; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= resp_new;
      for (int i = 1; i < RespLatency; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Grant stall counter: counts held-but-unaccepted cycles, saturating at GntDelay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (!req_i || accept) begin
      stall_cnt <= '0;
    end else if (stall_cnt < 4'(GntDelay)) begin
      stall_cnt <= stall_cnt + 4'd1;
    end
  end

  // Outstanding count: accepted responses not yet presented on rvalid_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else if (accept && !rvalid_o) begin
      outstanding <= outstanding + 4'd1;
    end else if (!accept && rvalid_o) begin
      outstanding <= outstanding - 4'd1;
    end
  end

  // Out-of-reset flag, first set on the edge after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) active <= 1'b0;
    else         active <= 1'b1;
  end

  assign rvalid_o     = pipe[RespLatency-1].vld;
  assign rdata_o      = pipe[RespLatency-1].rdata;
  assign rdata_intg_o = pipe[RespLatency-1].intg;
  assign err_o        = pipe[RespLatency-1].err;

  a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({gnt_o, rvalid_o, err_o}));
  a_out_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding <= 4'(MaxOutstanding));
  a_rvalid_out: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_o |-> (outstanding != 4'd0));

endmodule

// File: tb/tb_cve2_mem_responder.sv
// Bench for cve2_mem_responder: three instances (defaults, GntDelay=2/RespLatency=4, RespLatency=4 limit).
// Stimulus pushes expected responses into per-instance queues; a negedge monitor pops and compares.
// Also tracks outstanding per instance to confirm grant is withheld at the limit.
module tb_cve2_mem_responder;

  localparam int N = 3;
  localparam int MAXO = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [6:0]  intg;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        req;
  logic [N-1:0]        gnt;
  logic [N-1:0]        we;
  logic [N-1:0][3:0]   be;
  logic [N-1:0][31:0]  addr;
  logic [N-1:0][31:0]  wdata;
  logic [N-1:0][6:0]   wintg;
  logic [N-1:0]        rvalid;
  logic [N-1:0][31:0]  rdata;
  logic [N-1:0][6:0]   rintg;
  logic [N-1:0]        err;

  exp_t exp_q [N][$];
  exp_t mon_e;
  int   n_cmp;
  int   n_bad;
  int   model_out [N];
  int   max_out [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cve2_mem_responder u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .wdata_intg_i(wintg[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .rdata_intg_o(rintg[0]), .err_o(err[0]));

  cve2_mem_responder #(.GntDelay(2), .RespLatency(4), .MaxOutstanding(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .wdata_intg_i(wintg[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .rdata_intg_o(rintg[1]), .err_o(err[1]));

  cve2_mem_responder #(.GntDelay(0), .RespLatency(4), .MaxOutstanding(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .wdata_intg_i(wintg[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .rdata_intg_o(rintg[2]), .err_o(err[2]));

  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c ^ 7'h2A;
  endfunction

  function automatic logic [6:0] exp_intg(input logic [31:0] d);
`ifdef CVE2_MEM_RESP_INTG_EN
    return enc(d);
`else
    return 7'h00 & d[6:0];
`endif
  endfunction

  function void check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endfunction

  // Issue one request on instance d, measuring cycles until grant; called just after a rising edge.
  task automatic do_req(input int d, input bit w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] wd, input logic [6:0] intg_flip,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_wait,
                        input string tag);
    int waits;
    exp_t e;
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    wintg[d] = enc(wd) ^ intg_flip;
    waits = 0;
    @(negedge clk);
    while (gnt[d] !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    check({tag, "_gnt_wait"}, 64'(waits), 64'(exp_wait));
    if (gnt[d] === 1'b1) begin
      e.rdata = exp_rd; e.err = exp_err; e.intg = exp_intg(exp_rd);
      exp_q[d].push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d);
    req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor and outstanding model.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < N; d++) begin
        exp_q[d].delete();
        model_out[d] = 0;
      end
    end else begin
      for (int d = 0; d < N; d++) begin
        if (req[d] && model_out[d] >= MAXO) check($sformatf("gnt_blocked_dut%0d", d), 64'(gnt[d]), 64'd0);
        if (rvalid[d]) begin
          if (exp_q[d].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_rvalid dut%0d: got rvalid=1, expected none", d);
          end else begin
            mon_e = exp_q[d].pop_front();
            check($sformatf("rdata_dut%0d", d), 64'(rdata[d]), 64'(mon_e.rdata));
            check($sformatf("err_dut%0d", d), 64'(err[d]), 64'(mon_e.err));
            check($sformatf("rintg_dut%0d", d), 64'(rintg[d]), 64'(mon_e.intg));
          end
        end
        model_out[d] = model_out[d] + int'(req[d] & gnt[d]) - int'(rvalid[d]);
        if (model_out[d] > max_out[d]) max_out[d] = model_out[d];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int d = 0; d < N; d++) begin model_out[d] = 0; max_out[d] = 0; end
    rst_n = 1'b0;
    req = '1; we = '0; be = '0; addr = '0; wdata = '0; wintg = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("rst_gnt_dut%0d", d), 64'(gnt[d]), 64'd0);
      check($sformatf("rst_rvalid_dut%0d", d), 64'(rvalid[d]), 64'd0);
      check($sformatf("rst_rdata_dut%0d", d), 64'(rdata[d]), 64'd0);
      check($sformatf("rst_err_dut%0d", d), 64'(err[d]), 64'd0);
      check($sformatf("rst_rintg_dut%0d", d), 64'(rintg[d]), 64'd0);
    end
    req = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Defaults: write then back-to-back read, 1-cycle response.
    do_req(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 7'h0, 32'h0, 0, 0, "a_wr10");
    do_req(0, 0, 4'hF, 32'h10, 32'h0, 7'h0, 32'hDEAD_BEEF, 0, 0, "a_rd10");
    req[0] = 1'b0;
    @(negedge clk);
    check("a_rd_latency", 64'(rvalid[0]), 64'd1);
    @(posedge clk); #1;
    // Byte enables.
    do_req(0, 1, 4'b0101, 32'h10, 32'h1122_3344, 7'h0, 32'h0, 0, 0, "a_wr_be");
    do_req(0, 0, 4'hF, 32'h10, 32'h0, 7'h0, 32'hDE22_BE44, 0, 0, "a_rd_be");
    // Out of range read and write; word 0 unaffected.
    do_req(0, 1, 4'hF, 32'h0, 32'hCAFE_F00D, 7'h0, 32'h0, 0, 0, "a_wr0");
    do_req(0, 0, 4'hF, 32'h1000, 32'h0, 7'h0, 32'h0, 1, 0, "a_rd_oor");
    do_req(0, 1, 4'hF, 32'hFFFF_FFF0, 32'h0BAD_0BAD, 7'h0, 32'h0, 1, 0, "a_wr_oor");
    do_req(0, 0, 4'hF, 32'h0, 32'h0, 7'h0, 32'hCAFE_F00D, 0, 0, "a_rd0");
    // be=0 write is a no-op.
    do_req(0, 1, 4'hF, 32'h20, 32'h1234_5678, 7'h0, 32'h0, 0, 0, "a_wr20");
    do_req(0, 1, 4'h0, 32'h20, 32'hFFFF_FFFF, 7'h0, 32'h0, 0, 0, "a_wr20_be0");
    do_req(0, 0, 4'hF, 32'h20, 32'h0, 7'h0, 32'h1234_5678, 0, 0, "a_rd20");
    // Last word of the range, and low address bits ignored.
    do_req(0, 1, 4'hF, 32'hFFC, 32'h5A5A_A5A5, 7'h0, 32'h0, 0, 0, "a_wr_last");
    do_req(0, 0, 4'hF, 32'hFFC, 32'h0, 7'h0, 32'h5A5A_A5A5, 0, 0, "a_rd_last");
    do_req(0, 0, 4'hF, 32'h13, 32'h0, 7'h0, 32'hDE22_BE44, 0, 0, "a_rd_unaligned");
`ifdef CVE2_MEM_RESP_INTG_EN
    do_req(0, 1, 4'hF, 32'h30, 32'h0BAD_F00D, 7'h0, 32'h0, 0, 0, "a_wr30");
    do_req(0, 1, 4'hF, 32'h30, 32'hFFFF_FFFF, 7'h01, 32'h0, 1, 0, "a_wr30_badintg");
    do_req(0, 0, 4'hF, 32'h30, 32'h0, 7'h0, 32'h0BAD_F00D, 0, 0, "a_rd30");
`endif
    idle(0);

    // GntDelay=2, RespLatency=4: every held request granted on its 3rd cycle.
    do_req(1, 1, 4'hF, 32'h40, 32'hA5A5_0001, 7'h0, 32'h0, 0, 2, "b_wr40");
    do_req(1, 1, 4'hF, 32'h44, 32'hA5A5_0002, 7'h0, 32'h0, 0, 2, "b_wr44");
    do_req(1, 0, 4'hF, 32'h40, 32'h0, 7'h0, 32'hA5A5_0001, 0, 2, "b_rd40");
    do_req(1, 0, 4'hF, 32'h44, 32'h0, 7'h0, 32'hA5A5_0002, 0, 2, "b_rd44");
    idle(1);

    // RespLatency=4, no stall: third request waits for the first retirement.
    do_req(2, 1, 4'hF, 32'h0, 32'h1111_1111, 7'h0, 32'h0, 0, 0, "c_wr0");
    do_req(2, 1, 4'hF, 32'h4, 32'h2222_2222, 7'h0, 32'h0, 0, 0, "c_wr4");
    do_req(2, 0, 4'hF, 32'h0, 32'h0, 7'h0, 32'h1111_1111, 0, 3, "c_rd0");
    do_req(2, 0, 4'hF, 32'h4, 32'h0, 7'h0, 32'h2222_2222, 0, 0, "c_rd4");
    idle(2);
    repeat (8) @(posedge clk);
    #1;

    // Reset two cycles after a read accept: no response afterwards, RAM retained.
    do_req(1, 0, 4'hF, 32'h44, 32'h0, 7'h0, 32'hA5A5_0002, 0, 2, "b_rd_rst");
    idle(1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b_no_rvalid_after_rst", 64'(rvalid[1]), 64'd0);
    end
    @(posedge clk); #1;
    do_req(1, 0, 4'hF, 32'h40, 32'h0, 7'h0, 32'hA5A5_0001, 0, 2, "b_rd40_after_rst");
    idle(1);

    for (int i = 0; i < 50 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0; i++)
      @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N; d++) check($sformatf("drained_dut%0d", d), 64'(exp_q[d].size()), 64'd0);
    check("b_peak_outstanding", 64'(max_out[1]), 64'd2);
    check("c_peak_outstanding", 64'(max_out[2]), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
